alu_sequencer: RTL and testbench

//  Fetch/decode/execute controller that drives the 4-bit ALU: the command issuer for the ALU's command port.
//  - Fetches byte instructions from an async-read program ROM and issues ALU commands.
//  - Writes results back to a 4-bit accumulator; keeps carry/zero flags; branches on them.
//  - Sits between program ROM and ALU; top level of the 4-bit processor datapath.

---
 rtl/alu_seq_pkg.sv | 58 +++++
 rtl/alu_seq_pc.sv | 29 ++
 rtl/alu_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_alu_sequencer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the 4-bit ALU sequencer.
//   - Opcode constants (upper nibble of an instruction byte).
//   - ALU command constants driven on alu_cmd.
//   - FSM state encoding, also exported on the sequencer's debug port.
//   - Decode helpers used by the sequencer's next-state logic.
// Optional feature macro: ALU_SEQ_CALL_EN (makes CALL a two-byte instruction).
package alu_seq_pkg;

    localparam logic [3:0] OP_LIT   = 4'h0;
    localparam logic [3:0] OP_ADDI  = 4'h1;
    localparam logic [3:0] OP_CMPI  = 4'h2;
    localparam logic [3:0] OP_NANDI = 4'h3;
    localparam logic [3:0] OP_JMP   = 4'h4;
    localparam logic [3:0] OP_JC    = 4'h5;
    localparam logic [3:0] OP_JNC   = 4'h6;
    localparam logic [3:0] OP_JZ    = 4'h7;
    localparam logic [3:0] OP_JNZ   = 4'h8;
    localparam logic [3:0] OP_CALL  = 4'h9;
    localparam logic [3:0] OP_RET   = 4'hA;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [2:0] CMD_PASS_A = 3'b000;
    localparam logic [2:0] CMD_CMP    = 3'b001;
    localparam logic [2:0] CMD_PASS_B = 3'b010;
    localparam logic [2:0] CMD_ADD    = 3'b011;
    localparam logic [2:0] CMD_NAND   = 3'b100;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_ADDR2 = 2'd2,
        S_HALT  = 2'd3
    } seq_state_t;

    // Instructions that carry a second (address low) byte.
    function automatic logic is_two_byte(input logic [3:0] op);
        logic r;
        r = (op >= OP_JMP) && (op <= OP_JNZ);
`ifdef ALU_SEQ_CALL_EN
        r = r || (op == OP_CALL);
`endif
        return r;
    endfunction

    // Branch decision for a two-byte instruction; unconditional forms are always taken.
    function automatic logic jump_taken(input logic [3:0] op, input logic c, input logic z);
        logic r;
        case (op)
            OP_JC:   r = c;
            OP_JNC:  r = !c;
            OP_JZ:   r = z;
            OP_JNZ:  r = !z;
            default: r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_seq_pc.sv
// alu_seq_pc: program counter register for the ALU sequencer.
//   clk, rst   : clock and asynchronous active-high reset (pc -> 0)
//   inc        : pc <= pc + 1, wrapping from all-ones to zero
//   load       : pc <= load_val (takes priority over inc)
//   load_val   : value loaded when load is set
//   pc         : current program counter
// With neither inc nor load the register holds.
module alu_seq_pc #(
    parameter int PC_W = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc,
    input  logic            load,
    input  logic [PC_W-1:0] load_val,
    output logic [PC_W-1:0] pc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= '0;
        end else if (load) begin
            pc <= load_val;
        end else if (inc) begin
            pc <= pc + PC_W'(1);
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: fetch/decode/execute controller for a 4-bit ALU.
// Reads byte instructions {op, imm} from an async-read ROM addressed by pc,
// issues ALU commands, writes results to the accumulator, keeps carry/zero
// flags and branches on them.
// Ports:
//   clk, reset   : clock (rising edge), asynchronous active-high reset
//   enable       : 1 advances the FSM, 0 freezes every register
//   prog_byte    : ROM data at address pc
//   pc           : program counter / ROM address
//   alu_cmd      : ALU command (valid in EXEC, 000 otherwise)
//   alu_a, alu_b : ALU operands (A is the accumulator, B the immediate)
//   alu_result, alu_carry, alu_zero : ALU outputs, sampled at the end of EXEC
//   accu         : accumulator
//   c_flag, z_flag : registered carry / zero flags
//   halted       : high while the FSM sits in HALT
//   state        : current FSM state (debug)
// Flow control: there is no handshake; enable is a global stall. When enable
// is low no register changes, so combinational outputs (alu_cmd, alu_b) keep
// their values.
// Optional feature macro: ALU_SEQ_CALL_EN adds a one-entry return register
// with CALL (opcode 9, two bytes) and RET (opcode A). Without it both are NOPs.
import alu_seq_pkg::*;

module alu_sequencer #(
    parameter int PC_W = 12
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic [7:0]      prog_byte,
    output logic [PC_W-1:0] pc,
    output logic [2:0]      alu_cmd,
    output logic [3:0]      alu_a,
    output logic [3:0]      alu_b,
    input  logic [3:0]      alu_result,
    input  logic            alu_carry,
    input  logic            alu_zero,
    output logic [3:0]      accu,
    output logic            c_flag,
    output logic            z_flag,
    output logic            halted,
    output seq_state_t      state
);

    seq_state_t      next_state;
    logic [7:0]      instr;
    logic [3:0]      op;
    logic [3:0]      imm;
    logic [3:0]      fetch_op;
    logic            pc_inc;
    logic            pc_load;
    logic [PC_W-1:0] pc_load_val;
    logic            accu_we;
    logic            flags_we;
`ifdef ALU_SEQ_CALL_EN
    logic [PC_W-1:0] ret_pc;
    logic            ret_we;
`endif

    assign op       = instr[7:4];
    assign imm      = instr[3:0];
    assign fetch_op = prog_byte[7:4];
    assign alu_a    = accu;
    assign halted   = (state == S_HALT);

    alu_seq_pc #(
        .PC_W(PC_W)
    ) u_pc (
        .clk      (clk),
        .rst      (reset),
        .inc      (pc_inc && enable),
        .load     (pc_load && enable),
        .load_val (pc_load_val),
        .pc       (pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else if (enable) begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        pc_load_val = pc;
        alu_cmd     = CMD_PASS_A;
        alu_b       = 4'h0;
        accu_we     = 1'b0;
        flags_we    = 1'b0;
`ifdef ALU_SEQ_CALL_EN
        ret_we      = 1'b0;
`endif
        case (state)
            S_FETCH: begin
                pc_inc = 1'b1;
                if (fetch_op == OP_HALT) begin
                    next_state = S_HALT;
                end else if (is_two_byte(fetch_op)) begin
                    next_state = S_ADDR2;
                end else begin
                    next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                next_state = S_FETCH;
                case (op)
                    OP_LIT: begin
                        alu_cmd = CMD_PASS_B;
                        alu_b   = imm;
                        accu_we = 1'b1;
                    end
                    OP_ADDI: begin
                        alu_cmd  = CMD_ADD;
                        alu_b    = imm;
                        accu_we  = 1'b1;
                        flags_we = 1'b1;
                    end
                    OP_CMPI: begin
                        alu_cmd  = CMD_CMP;
                        alu_b    = imm;
                        flags_we = 1'b1;
                    end
                    OP_NANDI: begin
                        alu_cmd = CMD_NAND;
                        alu_b   = imm;
                        accu_we = 1'b1;
                    end
`ifdef ALU_SEQ_CALL_EN
                    OP_RET: begin
                        pc_load     = 1'b1;
                        pc_load_val = ret_pc;
                    end
`endif
                    default: begin
                    end
                endcase
            end
            S_ADDR2: begin
                // pc points at the second byte here; flags are the ones
                // registered before this instruction was fetched.
                next_state = S_FETCH;
`ifdef ALU_SEQ_CALL_EN
                ret_we = (op == OP_CALL);
`endif
                if (jump_taken(op, c_flag, z_flag)) begin
                    pc_load     = 1'b1;
                    pc_load_val = PC_W'({imm, prog_byte});
                end else begin
                    pc_inc = 1'b1;
                end
            end
            S_HALT: begin
            end
            default: begin
                next_state = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr  <= 8'h00;
            accu   <= 4'h0;
            c_flag <= 1'b0;
            z_flag <= 1'b0;
        end else if (enable) begin
            if (state == S_FETCH) begin
                instr <= prog_byte;
            end
            if (accu_we) begin
                accu <= alu_result;
            end
            if (flags_we) begin
                c_flag <= alu_carry;
                z_flag <= alu_zero;
            end
        end
    end

`ifdef ALU_SEQ_CALL_EN
    // Return address is the byte after the CALL's second byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ret_pc <= '0;
        end else if (enable && ret_we) begin
            ret_pc <= pc + PC_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed-program testbench for alu_sequencer with an ALU model and ROM.
// Expected retirement snapshots {halted, pc, accu, c, z} are queued per program;
// a monitor pops one each time an instruction completes.
import alu_seq_pkg::*;

module tb_alu_sequencer;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [7:0]  prog_byte;
    logic [11:0] pc;
    logic [2:0]  alu_cmd;
    logic [3:0]  alu_a;
    logic [3:0]  alu_b;
    logic [3:0]  alu_result;
    logic        alu_carry;
    logic        alu_zero;
    logic [3:0]  accu;
    logic        c_flag;
    logic        z_flag;
    logic        halted;
    seq_state_t  state;

    logic [7:0]  rom [0:4095];
    logic [18:0] exp_q[$];
    int          total = 0;
    int          bad = 0;
    seq_state_t  prev_state = S_FETCH;

    alu_sequencer #(.PC_W(12)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .prog_byte  (prog_byte),
        .pc         (pc),
        .alu_cmd    (alu_cmd),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .alu_carry  (alu_carry),
        .alu_zero   (alu_zero),
        .accu       (accu),
        .c_flag     (c_flag),
        .z_flag     (z_flag),
        .halted     (halted),
        .state      (state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign prog_byte = rom[pc];

    // ALU model: cmp is a - b with carry = borrow
    always_comb begin
        alu_result = alu_a;
        alu_carry  = 1'b0;
        case (alu_cmd)
            CMD_PASS_A: alu_result = alu_a;
            CMD_CMP:    {alu_carry, alu_result} = {1'b0, alu_a} - {1'b0, alu_b};
            CMD_PASS_B: alu_result = alu_b;
            CMD_ADD:    {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
            CMD_NAND:   alu_result = ~(alu_a & alu_b);
            default:    alu_result = alu_a;
        endcase
        alu_zero = (alu_result == 4'h0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [18:0] snap(input logic h, input logic [11:0] p,
                                         input logic [3:0] a, input logic c, input logic z);
        return {h, p, a, c, z};
    endfunction

    task automatic push(input logic h, input logic [11:0] p, input logic [3:0] a,
                        input logic c, input logic z);
        exp_q.push_back(snap(h, p, a, c, z));
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (reset) begin
            prev_state <= S_FETCH;
        end else begin
            if (state != S_EXEC) begin
                check("idle_cmd_b", 32'({alu_cmd, alu_b}), 32'd0);
            end
            if ((state == S_FETCH && (prev_state == S_EXEC || prev_state == S_ADDR2)) ||
                (state == S_HALT && prev_state != S_HALT)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_retire", 32'({halted, pc, accu, c_flag, z_flag}), 32'h7ffff);
                end else begin
                    check("retire", 32'({halted, pc, accu, c_flag, z_flag}), 32'(exp_q.pop_front()));
                end
            end
            prev_state <= state;
        end
    end

    // driver tasks
    task automatic put(input int addr, input logic [7:0] b);
        rom[addr] = b;
    endtask

    task automatic begin_prog();
        reset  = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4096; i++) rom[i] = 8'hF0;
        exp_q.delete();
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic finish_prog(input string name, input int budget);
        for (int i = 0; i < budget && !halted; i++) @(negedge clk);
        check({name, "_halted"}, 32'(halted), 32'd1);
        @(negedge clk);
        @(negedge clk);
        check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_state(input string name, input seq_state_t s, input logic [11:0] p,
                              input int budget);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (state == s && pc == p) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({name, "_reached"}, 32'(found), 32'd1);
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 4096; i++) rom[i] = 8'hF0;
        @(negedge clk);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_accu", 32'(accu), 32'd0);
        check("rst_flags", 32'({c_flag, z_flag}), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_cmd", 32'(alu_cmd), 32'd0);
        check("rst_b", 32'(alu_b), 32'd0);
        check("rst_state", 32'(state), 32'(S_FETCH));

        // LIT 5, ADDI C, HALT
        begin_prog();
        put(0, 8'h05); put(1, 8'h1C); put(2, 8'hF0);
        push(0, 12'h001, 4'h5, 0, 0);
        push(0, 12'h002, 4'h1, 1, 0);
        push(1, 12'h003, 4'h1, 1, 0);
        release_reset();
        finish_prog("basic", 40);

        // LIT 7, CMPI 7, JZ 0x040 taken
        begin_prog();
        put(0, 8'h07); put(1, 8'h27); put(2, 8'h70); put(3, 8'h40); put(12'h040, 8'hF0);
        push(0, 12'h001, 4'h7, 0, 0);
        push(0, 12'h002, 4'h7, 0, 1);
        push(0, 12'h040, 4'h7, 0, 1);
        push(1, 12'h041, 4'h7, 0, 1);
        release_reset();
        finish_prog("jz_taken", 40);

        // LIT 7, CMPI 6, JZ not taken
        begin_prog();
        put(0, 8'h07); put(1, 8'h26); put(2, 8'h70); put(3, 8'h40); put(4, 8'hF0);
        push(0, 12'h001, 4'h7, 0, 0);
        push(0, 12'h002, 4'h7, 0, 0);
        push(0, 12'h004, 4'h7, 0, 0);
        push(1, 12'h005, 4'h7, 0, 0);
        release_reset();
        finish_prog("jz_not", 40);

        // branch mix: JC/JNC/JNZ, NANDI flags untouched
        begin_prog();
        put(0, 8'h0F); put(1, 8'h11); put(2, 8'h50); put(3, 8'h08);
        put(8, 8'h60); put(9, 8'h20); put(10, 8'h80); put(11, 8'h30);
        put(12, 8'h35); put(13, 8'h20); put(14, 8'h80); put(15, 8'h20);
        put(12'h020, 8'h60); put(12'h021, 8'h30); put(12'h030, 8'hF0);
        push(0, 12'h001, 4'hF, 0, 0);
        push(0, 12'h002, 4'h0, 1, 1);
        push(0, 12'h008, 4'h0, 1, 1);
        push(0, 12'h00A, 4'h0, 1, 1);
        push(0, 12'h00C, 4'h0, 1, 1);
        push(0, 12'h00D, 4'hF, 1, 1);
        push(0, 12'h00E, 4'hF, 0, 0);
        push(0, 12'h020, 4'hF, 0, 0);
        push(0, 12'h030, 4'hF, 0, 0);
        push(1, 12'h031, 4'hF, 0, 0);
        release_reset();
        finish_prog("branches", 80);

        // JMP 0xFFE; JMP 0xFFF at 0xFFE; HALT at 0xFFF, fetch wraps pc to 0
        begin_prog();
        put(0, 8'h4F); put(1, 8'hFE); put(12'hFFE, 8'h4F); put(12'hFFF, 8'hFF);
        push(0, 12'hFFE, 4'h0, 0, 0);
        push(0, 12'hFFF, 4'h0, 0, 0);
        push(1, 12'h000, 4'h0, 0, 0);
        release_reset();
        finish_prog("wrap_fetch", 40);

        // JZ at 0xFFF: second byte at 0x000, not taken -> pc 0x001
        begin_prog();
        put(0, 8'h4F); put(1, 8'hFF); put(12'hFFF, 8'h70);
        push(0, 12'hFFF, 4'h0, 0, 0);
        push(0, 12'h001, 4'h0, 0, 0);
        push(1, 12'h002, 4'h0, 0, 0);
        release_reset();
        finish_prog("wrap_addr2", 40);

        // enable low for 5 cycles while ADDI sits in EXEC
        begin_prog();
        put(0, 8'h05); put(1, 8'h1C); put(2, 8'hF0);
        push(0, 12'h001, 4'h5, 0, 0);
        push(0, 12'h002, 4'h1, 1, 0);
        push(1, 12'h003, 4'h1, 1, 0);
        release_reset();
        wait_state("stall", S_EXEC, 12'h002, 20);
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_pc", 32'(pc), 32'h2);
            check("stall_accu", 32'(accu), 32'h5);
            check("stall_state", 32'(state), 32'(S_EXEC));
            check("stall_cmd", 32'(alu_cmd), 32'(CMD_ADD));
        end
        enable = 1'b1;
        finish_prog("stall", 40);

        // reset asserted during ADDR2 of JMP, then a clean rerun
        begin_prog();
        put(0, 8'h03); put(1, 8'h4F); put(2, 8'h00); put(12'hF00, 8'hF0);
        push(0, 12'h001, 4'h3, 0, 0);
        release_reset();
        wait_state("mid_rst", S_ADDR2, 12'h002, 20);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_pc", 32'(pc), 32'd0);
        check("mid_rst_accu", 32'(accu), 32'd0);
        check("mid_rst_flags", 32'({c_flag, z_flag}), 32'd0);
        check("mid_rst_state", 32'(state), 32'(S_FETCH));
        @(negedge clk);
        check("mid_rst_q", 32'(exp_q.size()), 32'd0);
        push(0, 12'h001, 4'h3, 0, 0);
        push(0, 12'hF00, 4'h3, 0, 0);
        push(1, 12'hF01, 4'h3, 0, 0);
        release_reset();
        finish_prog("mid_rst", 40);

`ifdef ALU_SEQ_CALL_EN
        // JMP 0x010; CALL 0x100; RET -> 0x012
        begin_prog();
        put(0, 8'h40); put(1, 8'h10); put(12'h010, 8'h91); put(12'h011, 8'h00);
        put(12'h100, 8'hA0); put(12'h012, 8'hF0);
        push(0, 12'h010, 4'h0, 0, 0);
        push(0, 12'h100, 4'h0, 0, 0);
        push(0, 12'h012, 4'h0, 0, 0);
        push(1, 12'h013, 4'h0, 0, 0);
        release_reset();
        finish_prog("call_ret", 40);
`else
        // opcodes 9 and A are one-byte NOPs
        begin_prog();
        put(0, 8'h90); put(1, 8'hA0); put(2, 8'h05); put(3, 8'hF0);
        push(0, 12'h001, 4'h0, 0, 0);
        push(0, 12'h002, 4'h0, 0, 0);
        push(0, 12'h003, 4'h5, 0, 0);
        push(1, 12'h004, 4'h5, 0, 0);
        release_reset();
        finish_prog("nop_9a", 40);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
